// File: rtl/frogger_pkg.sv
// Shared Frogger game definitions: FSM and direction encodings, default grid
// geometry, and the direction priority helpers used by the movement logic.
package frogger_pkg;

   typedef enum logic [1:0] {
      ST_ALIVE = 2'd0,
      ST_DEAD  = 2'd1,
      ST_OVER  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   localparam int DEF_COLS      = 20;
   localparam int DEF_ROWS      = 15;
   localparam int DEF_CELL_LOG2 = 5;
   localparam int DEF_START_COL = 10;

   // Key vectors are packed {up, down, left, right}, MSB first.
   function automatic dir_t prio_dir(input logic [3:0] keys);
      dir_t d;
      if (keys[3])      d = DIR_UP;
      else if (keys[2]) d = DIR_DOWN;
      else if (keys[1]) d = DIR_LEFT;
      else              d = DIR_RIGHT;
      return d;
   endfunction

   function automatic logic [3:0] dir_mask(input dir_t d);
      logic [3:0] m;
      case (d)
         DIR_UP:   m = 4'b1000;
         DIR_DOWN: m = 4'b0100;
         DIR_LEFT: m = 4'b0010;
         default:  m = 4'b0001;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/key_repeat.sv
// Rising-edge detection on the four direction keys plus hold-to-repeat timing
// for the accepted direction (first repeat after REPEAT_DLY, then every REPEAT_PER).
module key_repeat
   import frogger_pkg::*;
#(
   parameter int REPEAT_DLY = 12_500_000,
   parameter int REPEAT_PER = 5_000_000
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_En,
   input  logic [3:0] keys,
   output logic       fire,
   output dir_t       fire_dir
);

   localparam int CNT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

   logic [3:0]       keys_p0;
   logic             active;
   logic             first;
   dir_t             held;
   logic [CNT_W-1:0] cnt;

   logic [3:0]       rise;
   logic             alone;
   logic             tick;
   logic [CNT_W-1:0] target;

   always_comb begin
      rise     = keys & ~keys_p0;
      alone    = (keys == dir_mask(held));
      target   = first ? CNT_W'(REPEAT_DLY - 1) : CNT_W'(REPEAT_PER - 1);
      tick     = active && alone && (cnt == target);
      fire     = i_En && ((|rise) || tick);
      fire_dir = (|rise) ? prio_dir(rise) : held;
   end

   // Edge history keeps sampling even when disabled, so keys held through a
   // freeze must be released and pressed again before they count.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         keys_p0 <= '0;
         active  <= 1'b0;
         first   <= 1'b1;
         held    <= DIR_UP;
         cnt     <= '0;
      end else begin
         keys_p0 <= keys;
         if (!i_En) begin
            active <= 1'b0;
            cnt    <= '0;
         end else if (|rise) begin
            active <= 1'b1;
            first  <= 1'b1;
            held   <= prio_dir(rise);
            cnt    <= '0;
         end else if (active && alone) begin
            if (tick) begin
               cnt   <= '0;
               first <= 1'b0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            active <= 1'b0;
            cnt    <= '0;
         end
      end
   end

endmodule

// File: rtl/grid_mover.sv
// Grid-locked Frogger player controller: position and bounds, goal/level
// handling, lives, and the ALIVE/DEAD/OVER respawn state machine.
module grid_mover
   import frogger_pkg::*;
#(
   parameter int COLS        = DEF_COLS,
   parameter int ROWS        = DEF_ROWS,
   parameter int CELL_LOG2   = DEF_CELL_LOG2,
   parameter int START_COL   = DEF_START_COL,
   parameter int REPEAT_DLY  = 12_500_000,
   parameter int REPEAT_PER  = 5_000_000,
   parameter int RESPAWN_CYC = 25_000_000,
   parameter int LIVES       = 3,
   parameter int MAX_LEVEL   = 15
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Left,
   input  logic       i_Down,
   input  logic       i_Up,
   input  logic       i_Right,
   input  logic       i_Hit,
   output logic [4:0] o_Col,
   output logic [3:0] o_Row,
   output logic [9:0] o_X,
   output logic [9:0] o_Y,
   output logic [3:0] o_Level,
   output logic [2:0] o_Lives,
   output logic       o_Moved,
   output logic       o_Level_Up,
   output logic       o_Dead,
   output logic       o_Game_Over
);

   localparam int FRZ_W = (RESPAWN_CYC > 2) ? $clog2(RESPAWN_CYC) : 1;

   state_t           state;
   logic [FRZ_W-1:0] frz_cnt;
   logic             key_en;
   logic             fire;
   dir_t             fire_dir;

   // A hit in the same cycle as a move wins, so the key logic is held off.
   assign key_en = (state == ST_ALIVE) && !i_Hit;

   key_repeat #(
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
   ) u_key_repeat (
      .i_Clk    (i_Clk),
      .i_Rst    (i_Rst),
      .i_En     (key_en),
      .keys     ({i_Up, i_Down, i_Left, i_Right}),
      .fire     (fire),
      .fire_dir (fire_dir)
   );

   assign o_X = 10'(o_Col) << CELL_LOG2;
   assign o_Y = 10'(o_Row) << CELL_LOG2;

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state       <= ST_ALIVE;
         frz_cnt     <= '0;
         o_Col       <= 5'(START_COL);
         o_Row       <= 4'(ROWS - 1);
         o_Level     <= 4'd1;
         o_Lives     <= 3'(LIVES);
         o_Moved     <= 1'b0;
         o_Level_Up  <= 1'b0;
         o_Dead      <= 1'b0;
         o_Game_Over <= 1'b0;
      end else begin
         o_Moved    <= 1'b0;
         o_Level_Up <= 1'b0;
         case (state)
            ST_ALIVE: begin
               if (i_Hit) begin
                  state   <= ST_DEAD;
                  o_Lives <= o_Lives - 1'b1;
                  o_Dead  <= 1'b1;
                  frz_cnt <= '0;
               end else if (fire) begin
                  case (fire_dir)
                     DIR_UP: begin
                        if (o_Row == 4'd1) begin
                           o_Row      <= 4'(ROWS - 1);
                           o_Col      <= 5'(START_COL);
                           o_Moved    <= 1'b1;
                           o_Level_Up <= 1'b1;
                           if (o_Level != 4'(MAX_LEVEL))
                              o_Level <= o_Level + 1'b1;
                        end else if (o_Row != 4'd0) begin
                           o_Row   <= o_Row - 1'b1;
                           o_Moved <= 1'b1;
                        end
                     end
                     DIR_DOWN: begin
                        if (o_Row != 4'(ROWS - 1)) begin
                           o_Row   <= o_Row + 1'b1;
                           o_Moved <= 1'b1;
                        end
                     end
                     DIR_LEFT: begin
                        if (o_Col != 5'd0) begin
                           o_Col   <= o_Col - 1'b1;
                           o_Moved <= 1'b1;
                        end
                     end
                     default: begin
                        if (o_Col != 5'(COLS - 1)) begin
                           o_Col   <= o_Col + 1'b1;
                           o_Moved <= 1'b1;
                        end
                     end
                  endcase
               end
            end
            ST_DEAD: begin
               if (frz_cnt == FRZ_W'(RESPAWN_CYC - 1)) begin
                  o_Dead <= 1'b0;
                  if (o_Lives != 3'd0) begin
                     state <= ST_ALIVE;
                     o_Col <= 5'(START_COL);
                     o_Row <= 4'(ROWS - 1);
                  end else begin
                     state       <= ST_OVER;
                     o_Game_Over <= 1'b1;
                  end
               end else begin
                  frz_cnt <= frz_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
